// File: rtl/raw_bayer_rx_checker.sv
// Receive-side checker for raw Bayer fv/lv/data streams: frame sync, geometry measurement, colorbar compare.
// Optional RAW_RX_PATTERN_CHECK_EN builds the per-pixel compare and saturating error accumulator.
module raw_bayer_rx_checker #(
    parameter int WORD_WIDTH    = 10,
    parameter int H_ACTIVE      = 1920,
    parameter int V_ACTIVE      = 1080,
    parameter int BAR_WIDTH     = 160,
    parameter int BAYER_PATTERN = 3,
    parameter int ERR_W         = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fv,
    input  logic                  lv,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  frame_done,
    output logic [11:0]           line_len,
    output logic [11:0]           frame_lines,
    output logic                  geom_err,
    output logic [ERR_W-1:0]      pix_err_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  locked,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {SYNC, WAIT_FV, FRAME} state_t;

    localparam logic [1:0]  C_R      = 2'd0;
    localparam logic [1:0]  C_G      = 2'd1;
    localparam logic [1:0]  C_B      = 2'd2;
    localparam logic [11:0] BAR_LAST = 12'(BAR_WIDTH - 1);

    state_t                state, state_nxt;
    logic                  fv_q, lv_q, lv_d, in_vld;
    logic [WORD_WIDTH-1:0] data_q;
    logic [11:0]           col, row, bar_cnt;
    logic [1:0]            bar_idx;
    logic                  line_act, geom_flag, geom_pend;
    logic                  start, frame_end, pix, line_close;
    logic [11:0]           col_b, row_b, bar_cnt_b, row_inc;
    logic [1:0]            bar_idx_b, site_clr;
    logic [WORD_WIDTH-1:0] exp_pix;
    logic [ERR_W-1:0]      acc;
    logic                  end_q, res_vld, res_geom;
    logic [11:0]           res_lines;
    logic [ERR_W-1:0]      res_err;

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        frame_end = 1'b0;
        case (state)
            SYNC:    if (in_vld && !fv_q) state_nxt = WAIT_FV;
            WAIT_FV: if (fv_q) begin
                start     = 1'b1;
                state_nxt = FRAME;
            end
            FRAME:   if (!fv_q) begin
                frame_end = 1'b1;
                state_nxt = WAIT_FV;
            end
            default: state_nxt = SYNC;
        endcase
    end

    // The cycle that opens a frame may already carry its first pixel, so counters are muxed to zero.
    assign pix        = fv_q && lv_q && (state == FRAME || start);
    assign line_close = (state == FRAME) && lv_d && !lv_q && line_act;
    assign col_b      = start ? 12'd0 : col;
    assign row_b      = start ? 12'd0 : row;
    assign bar_cnt_b  = start ? 12'd0 : bar_cnt;
    assign bar_idx_b  = start ? C_R : bar_idx;
    assign row_inc    = (row == 12'hFFF) ? row : row + 12'd1;

    always_comb begin
        site_clr = C_G;
        case ({row_b[0], col_b[0]})
            2'b00:   site_clr = (BAYER_PATTERN == 0) ? C_R : (BAYER_PATTERN == 3) ? C_B : C_G;
            2'b01:   site_clr = (BAYER_PATTERN == 1) ? C_R : (BAYER_PATTERN == 2) ? C_B : C_G;
            2'b10:   site_clr = (BAYER_PATTERN == 1) ? C_B : (BAYER_PATTERN == 2) ? C_R : C_G;
            default: site_clr = (BAYER_PATTERN == 0) ? C_B : (BAYER_PATTERN == 3) ? C_R : C_G;
        endcase
    end

    assign exp_pix = (site_clr == bar_idx_b) ? {WORD_WIDTH{1'b1}} : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= SYNC;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            lv_d        <= 1'b0;
            in_vld      <= 1'b0;
            data_q      <= '0;
            col         <= '0;
            row         <= '0;
            bar_cnt     <= '0;
            bar_idx     <= C_R;
            line_act    <= 1'b0;
            geom_flag   <= 1'b0;
            geom_pend   <= 1'b0;
            line_len    <= '0;
            end_q       <= 1'b0;
            res_vld     <= 1'b0;
            res_lines   <= '0;
            res_geom    <= 1'b0;
            res_err     <= '0;
            frame_done  <= 1'b0;
            frame_lines <= '0;
            geom_err    <= 1'b0;
            pix_err_cnt <= '0;
            frame_cnt   <= '0;
            locked      <= 1'b0;
        end else begin
            fv_q   <= fv;
            lv_q   <= lv;
            lv_d   <= lv_q;
            in_vld <= 1'b1;
            data_q <= data;
            if (start) begin
                row       <= '0;
                geom_flag <= geom_pend;
                geom_pend <= 1'b0;
            end else if (state == WAIT_FV && lv_q) begin
                geom_pend <= 1'b1;
            end
            if (pix) begin
                col      <= (col_b == 12'hFFF) ? col_b : col_b + 12'd1;
                line_act <= 1'b1;
                if (bar_cnt_b == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= (bar_idx_b == C_B) ? C_R : bar_idx_b + 2'd1;
                end else begin
                    bar_cnt <= bar_cnt_b + 12'd1;
                    bar_idx <= bar_idx_b;
                end
            end else if (start || line_close) begin
                col      <= '0;
                bar_cnt  <= '0;
                bar_idx  <= C_R;
                line_act <= 1'b0;
            end
            if (line_close) begin
                line_len <= col;
                row      <= row_inc;
                if (col != 12'(H_ACTIVE)) geom_flag <= 1'b1;
            end
            // Snapshot one cycle after frame end so the last pixel has reached the accumulator,
            // but before a back-to-back frame start clears it.
            end_q <= frame_end;
            if (end_q) begin
                res_lines <= row;
                res_geom  <= geom_flag || (row != 12'(V_ACTIVE));
                res_err   <= acc;
            end
            res_vld    <= end_q;
            frame_done <= res_vld;
            if (res_vld) begin
                frame_lines <= res_lines;
                geom_err    <= res_geom;
                pix_err_cnt <= res_err;
                frame_cnt   <= frame_cnt + 16'd1;
                locked      <= !res_geom && (res_err == '0);
            end
        end
    end

`ifdef RAW_RX_PATTERN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mis_q <= 1'b0;
            acc   <= '0;
        end else begin
            mis_q <= pix && (data_q != exp_pix);
            if (start)                     acc <= '0;
            else if (mis_q && acc != '1)   acc <= acc + 1'b1;
        end
    end
`else
    logic unused_pix;

    assign acc        = '0;
    assign unused_pix = ^{data_q, exp_pix};
`endif

endmodule

// File: tb/tb_raw_bayer_rx_checker.sv
// Randomized self-checking bench for raw_bayer_rx_checker on a scaled-down frame geometry.
// A frame-level reference model predicts each frame_done result; a scoreboard queue holds them.
module tb_raw_bayer_rx_checker;

    localparam int WW  = 10;
    localparam int H   = 32;
    localparam int V   = 10;
    localparam int BW  = 4;
    localparam int PAT = 3;
    localparam int EW  = 8;
    localparam int EXP_W = 50;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fv, lv;
    logic [WW-1:0] data;
    logic          frame_done;
    logic [11:0]   line_len, frame_lines;
    logic          geom_err, locked;
    logic [EW-1:0] pix_err_cnt;
    logic [15:0]   frame_cnt;
    logic [1:0]    dbg_state;

    raw_bayer_rx_checker #(
        .WORD_WIDTH(WW), .H_ACTIVE(H), .V_ACTIVE(V),
        .BAR_WIDTH(BW), .BAYER_PATTERN(PAT), .ERR_W(EW)
    ) dut (
        .clk(clk), .rstn(rstn), .fv(fv), .lv(lv), .data(data),
        .frame_done(frame_done), .line_len(line_len), .frame_lines(frame_lines),
        .geom_err(geom_err), .pix_err_cnt(pix_err_cnt), .frame_cnt(frame_cnt),
        .locked(locked), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    int unsigned      fall_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               m_frames = 0;
    int               cur_mis;

    // colour of each 2x2 site for RGGB, GRBG, GBRG, BGGR (0=R, 1=G, 2=B)
    int bayer_tab [4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_val(input int r, input int c);
        int site, bar;
        site = bayer_tab[PAT][(r % 2) * 2 + (c % 2)];
        bar  = (c / BW) % 3;
        return (site == bar) ? {WW{1'b1}} : {WW{1'b0}};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_line(input int r, input int len, input int mode);
        logic [WW-1:0] e, d;
        for (int c = 0; c < len; c++) begin
            e = exp_val(r, c);
            case (mode)
                1:       d = (r == 0 && c == 0) ? ~e : e;
                2:       d = ~e;
                3:       d = ($urandom_range(0, 31) == 0) ? WW'($urandom) : e;
                default: d = e;
            endcase
            if (d != e) cur_mis++;
            lv   = 1'b1;
            data = d;
            cycle();
        end
    endtask

    task automatic drive_frame(input int nlines, input int short_row, input int short_len,
                               input int mode, input int vblank, input bit expect_done);
        int len, last_len, pix;
        bit coincide, geom, lck;
        cur_mis  = 0;
        last_len = 0;
        geom     = (nlines != V);
        coincide = 1'($urandom_range(0, 1));
        fv = 1'b1;
        lv = 1'b0;
        repeat ($urandom_range(0, 2)) cycle();
        for (int r = 0; r < nlines; r++) begin
            len = (r == short_row) ? short_len : H;
            if (len != H) geom = 1'b1;
            drive_line(r, len, mode);
            last_len = len;
            if (!(coincide && r == nlines - 1)) begin
                lv = 1'b0;
                repeat ($urandom_range(1, 3)) cycle();
            end
        end
        lv   = 1'b0;
        fv   = 1'b0;
        data = '0;
        if (expect_done) begin
`ifdef RAW_RX_PATTERN_CHECK_EN
            pix = (cur_mis > (2 ** EW) - 1) ? (2 ** EW) - 1 : cur_mis;
`else
            pix = 0;
`endif
            lck = !geom && (pix == 0);
            m_frames++;
            exp_q.push_back({12'(nlines), 12'(last_len), geom, EW'(pix), 16'(m_frames), lck});
            fall_q.push_back(cyc);
        end
        repeat (vblank) cycle();
    endtask

    // result monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        int unsigned f;
        if (rstn === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                f = fall_q.pop_front();
                check("frame_lines", frame_lines, e[49:38]);
                check("line_len",    line_len,    e[37:26]);
                check("geom_err",    geom_err,    e[25]);
                check("pix_err_cnt", pix_err_cnt, e[24:17]);
                check("frame_cnt",   frame_cnt,   e[16:1]);
                check("locked",      locked,      e[0]);
                check("done_latency", cyc - f,    32'd4);
            end
        end
    end

    initial begin
        int nl, sr, sl;
        rstn = 1'b0;
        fv   = 1'b1;
        lv   = 1'b0;
        data = '0;
        repeat (3) cycle();
        @(negedge clk);
        check("rst_frame_done",  frame_done,  0);
        check("rst_line_len",    line_len,    0);
        check("rst_frame_lines", frame_lines, 0);
        check("rst_geom_err",    geom_err,    0);
        check("rst_pix_err_cnt", pix_err_cnt, 0);
        check("rst_frame_cnt",   frame_cnt,   0);
        check("rst_locked",      locked,      0);
        cycle();
        drive_line(0, H, 0);
        lv = 1'b0;
        cycle();
        // release reset in the middle of a frame; the partial frame must not report
        rstn = 1'b1;
        for (int r = 0; r < 3; r++) begin
            drive_line(r + 3, H, 0);
            lv = 1'b0;
            repeat (2) cycle();
        end
        fv = 1'b0;
        repeat (4) cycle();

        drive_frame(V, -1, 0, 0, 2, 1'b1);
        drive_frame(V, -1, 0, 0, 2, 1'b1);
        drive_frame(V, -1, 0, 1, 2, 1'b1);
        drive_frame(V, 5, H - 1, 0, 2, 1'b1);
        drive_frame(V - 1, -1, 0, 0, 1, 1'b1);
        drive_frame(V, -1, 0, 0, 1, 1'b1);
        drive_frame(V, -1, 0, 2, 3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            nl = $urandom_range(V - 1, V + 1);
            sr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nl - 1) : -1;
            sl = ($urandom_range(0, 1) == 1) ? H - 1 : H + 1;
            drive_frame(nl, sr, sl, $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
        end

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle();
        check("pending_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
